// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the stepper move-command scheduler.
package step_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Position increment per strobe, in half-step units
  localparam int unsigned POS_HALF = 1;
  localparam int unsigned POS_FULL = 2;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter with a zero flag. Load wins over decrement;
// decrement saturates at zero.
module step_timer #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VALUE,
  input  logic         DEC,
  output logic [W-1:0] COUNT,
  output logic         ZERO
);

  assign ZERO = (COUNT == '0);

  // Counter register: reset, load, or saturating decrement
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COUNT <= '0;
    end else if (LOAD) begin
      COUNT <= LOAD_VALUE;
    end else if (DEC && !ZERO) begin
      COUNT <= COUNT - W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Move-command scheduler for the stepper phase controller.
// Accepts a move over CMD_VALID/CMD_READY and issues ENABLE strobes spaced
// max(CMD_PERIOD,1) clocks apart, tracking absolute position in half-steps.
// Optional build macro STEP_RAMP_EN: step k uses period P + max(RAMP_MAX-k, 0).
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned RAMP_MAX = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [STEP_W-1:0]   CMD_STEPS,
  input  logic                CMD_DIR,
  input  logic                CMD_HALF,
  input  logic [PERIOD_W-1:0] CMD_PERIOD,
  input  logic                ABORT,
  output logic                ENABLE,
  output logic                HALF_FULL,
  output logic                UP_DOWN,
  output logic                BUSY,
  output logic                DONE,
  output logic                ABORTED,
  output logic [STEP_W-1:0]   POSITION
);

  // Wide enough for (period - 1) plus the largest ramp extra
  localparam int unsigned TMR_W = $clog2((64'd1 << PERIOD_W) + 64'(RAMP_MAX));

  state_t              state;
  logic [STEP_W-1:0]   remaining;
  logic [PERIOD_W-1:0] per_m1;
  logic [PERIOD_W-1:0] cmd_pm1;
  logic                run;
  logic                accept;
  logic                fire;
  logic                tmr_zero;
  logic [TMR_W-1:0]    tmr_count;
  logic [TMR_W-1:0]    tmr_load_val;
  logic [STEP_W-1:0]   pos_step;

  assign run     = (state == ST_RUN);
  assign accept  = (state == ST_IDLE) && CMD_VALID;
  assign cmd_pm1 = (CMD_PERIOD == '0) ? '0 : CMD_PERIOD - PERIOD_W'(1);

  // Strobe cycle is decoded from registered timer/count state; ABORT is
  // gated in directly so it suppresses a strobe falling in the same cycle.
  assign fire = run && tmr_zero && (remaining != '0) && !ABORT;

`ifdef STEP_RAMP_EN
  localparam int unsigned RAMP_W = (RAMP_MAX > 0) ? $clog2(RAMP_MAX + 1) : 1;

  logic [RAMP_W-1:0] ramp_count;
  logic [RAMP_W-1:0] ramp_next;
  logic              ramp_zero;

  step_timer #(
    .W(RAMP_W)
  ) u_ramp (
    .CLK        (CLK),
    .RESET      (RESET),
    .LOAD       (accept),
    .LOAD_VALUE (RAMP_W'(RAMP_MAX)),
    .DEC        (fire),
    .COUNT      (ramp_count),
    .ZERO       (ramp_zero)
  );

  // Reload uses the extra delay the following step will see
  assign ramp_next    = ramp_zero ? '0 : ramp_count - RAMP_W'(1);
  assign tmr_load_val = accept ? TMR_W'(cmd_pm1) + TMR_W'(RAMP_MAX)
                               : TMR_W'(per_m1) + TMR_W'(ramp_next);
`else
  assign tmr_load_val = accept ? TMR_W'(cmd_pm1) : TMR_W'(per_m1);
`endif

  step_timer #(
    .W(TMR_W)
  ) u_period (
    .CLK        (CLK),
    .RESET      (RESET),
    .LOAD       (accept || fire),
    .LOAD_VALUE (tmr_load_val),
    .DEC        (run),
    .COUNT      (tmr_count),
    .ZERO       (tmr_zero)
  );

  // Only the zero flag of the period timer drives behaviour
  logic unused_tmr_count;
  assign unused_tmr_count = ^tmr_count;

  assign pos_step  = HALF_FULL ? STEP_W'(POS_HALF) : STEP_W'(POS_FULL);
  assign ENABLE    = fire;
  assign BUSY      = run;
  assign CMD_READY = !run;

  // Command accept, step accounting, position tracking and completion pulses
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      HALF_FULL <= 1'b1;
      UP_DOWN   <= 1'b1;
      DONE      <= 1'b0;
      ABORTED   <= 1'b0;
      POSITION  <= '0;
      remaining <= '0;
      per_m1    <= '0;
    end else begin
      DONE    <= 1'b0;
      ABORTED <= 1'b0;
      if (!run) begin
        if (CMD_VALID) begin
          UP_DOWN   <= CMD_DIR;
          HALF_FULL <= CMD_HALF;
          remaining <= CMD_STEPS;
          per_m1    <= cmd_pm1;
          if (CMD_STEPS == '0) begin
            DONE <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
      end else begin
        if (ABORT) begin
          DONE    <= 1'b1;
          ABORTED <= 1'b1;
          state   <= ST_IDLE;
        end else if (fire) begin
          remaining <= remaining - STEP_W'(1);
          POSITION  <= UP_DOWN ? POSITION + pos_step : POSITION - pos_step;
          if (remaining == STEP_W'(1)) begin
            DONE  <= 1'b1;
            state <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
